// File: rtl/multi_clk_gen_if.sv
// multi_clk_gen_if: valid/ready configuration port of multi_clk_gen.
// cfg_phase is present only when MULTI_CLK_GEN_PHASE_EN is defined.
interface multi_clk_gen_if #(
    parameter int NUM_CH = 2,
    parameter int DIV_W  = 16
);
    localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [DIV_W-1:0] cfg_div;
`ifdef MULTI_CLK_GEN_PHASE_EN
    logic [DIV_W-1:0] cfg_phase;
    modport master (output cfg_valid, cfg_ch, cfg_div, cfg_phase, input cfg_ready);
    modport slave  (input cfg_valid, cfg_ch, cfg_div, cfg_phase, output cfg_ready);
`else
    modport master (output cfg_valid, cfg_ch, cfg_div, input cfg_ready);
    modport slave  (input cfg_valid, cfg_ch, cfg_div, output cfg_ready);
`endif
endinterface

// File: rtl/multi_clk_gen.sv
// multi_clk_gen: runtime-reconfigurable divided-clock bank with PLL-style settle/lock.
// MULTI_CLK_GEN_PHASE_EN adds a per-channel start phase captured with each config transfer.
module multi_clk_gen #(
    parameter int                      NUM_CH     = 2,
    parameter int                      DIV_W      = 16,
    parameter int                      SETTLE_CYC = 64,
    parameter logic [NUM_CH*DIV_W-1:0] DEF_DIV    = {16'd4, 16'd2}
) (
    input  logic              refclk,
    input  logic              rst,
    multi_clk_gen_if.slave    cfg,
    output logic [NUM_CH-1:0] outclk,
    output logic [NUM_CH-1:0] outclk_en,
    output logic              locked
);
    localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam int SC_W = SETTLE_CYC > 1 ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CH_W:0] NCH = (CH_W+1)'(NUM_CH);

    typedef enum logic {SETTLE, RUN} state_t;
    state_t state;

    logic [SC_W-1:0]  scnt;
    logic [DIV_W-1:0] div   [NUM_CH];
    logic [DIV_W-1:0] cnt   [NUM_CH];
    logic [DIV_W-1:0] nxt   [NUM_CH];
    logic [DIV_W-1:0] half  [NUM_CH];
    logic [DIV_W-1:0] start [NUM_CH];
`ifdef MULTI_CLK_GEN_PHASE_EN
    logic [DIV_W-1:0] phase [NUM_CH];
`endif

    function automatic logic [DIV_W-1:0] clamp(input logic [DIV_W-1:0] d);
        return d < DIV_W'(2) ? DIV_W'(2) : d;
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            half[i] = (div[i] >> 1) + DIV_W'(div[i][0]);
            nxt[i]  = cnt[i] == div[i] - 1'b1 ? '0 : cnt[i] + 1'b1;
`ifdef MULTI_CLK_GEN_PHASE_EN
            start[i] = phase[i] > div[i] - 1'b1 ? div[i] - 1'b1 : phase[i];
`else
            start[i] = '0;
`endif
        end
    end

    // Outputs are registered from the count the channel will hold next cycle.
    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            state         <= SETTLE;
            scnt          <= '0;
            outclk        <= '0;
            outclk_en     <= '0;
            locked        <= 1'b0;
            cfg.cfg_ready <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                div[i] <= clamp(DEF_DIV[i*DIV_W +: DIV_W]);
                cnt[i] <= '0;
`ifdef MULTI_CLK_GEN_PHASE_EN
                phase[i] <= '0;
`endif
            end
        end else if (state == SETTLE) begin
            if (scnt == SC_W'(SETTLE_CYC - 1)) begin
                state         <= RUN;
                locked        <= 1'b1;
                cfg.cfg_ready <= 1'b1;
                for (int i = 0; i < NUM_CH; i++) begin
                    cnt[i]       <= start[i];
                    outclk[i]    <= start[i] < half[i];
                    outclk_en[i] <= start[i] == '0;
                end
            end else begin
                scnt <= scnt + 1'b1;
            end
        end else if (cfg.cfg_valid && cfg.cfg_ready && {1'b0, cfg.cfg_ch} < NCH) begin
            state              <= SETTLE;
            scnt               <= '0;
            outclk             <= '0;
            outclk_en          <= '0;
            locked             <= 1'b0;
            cfg.cfg_ready      <= 1'b0;
            div[cfg.cfg_ch]    <= clamp(cfg.cfg_div);
`ifdef MULTI_CLK_GEN_PHASE_EN
            phase[cfg.cfg_ch]  <= cfg.cfg_phase;
`endif
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i]       <= nxt[i];
                outclk[i]    <= nxt[i] < half[i];
                outclk_en[i] <= nxt[i] == '0;
            end
        end
    end
endmodule

// File: tb/tb_multi_clk_gen.sv
// tb_multi_clk_gen: directed checks of lock timing, divide patterns, reconfig, clamp and reset.
// A second 3-channel instance covers an out-of-range channel select.
module tb_multi_clk_gen;
    logic refclk = 1'b0;
    logic rst = 1'b0;
    logic [1:0] outclk, outclk_en;
    logic locked;
    logic [2:0] outclk3, outclk_en3;
    logic locked3;
    int n_vec = 0;
    int n_bad = 0;

    multi_clk_gen_if #(.NUM_CH(2), .DIV_W(16)) if_m ();
    multi_clk_gen_if #(.NUM_CH(3), .DIV_W(8))  if_3 ();

    multi_clk_gen dut (
        .refclk(refclk), .rst(rst), .cfg(if_m.slave),
        .outclk(outclk), .outclk_en(outclk_en), .locked(locked)
    );

    multi_clk_gen #(.NUM_CH(3), .DIV_W(8), .SETTLE_CYC(4), .DEF_DIV({8'd3, 8'd4, 8'd2})) dut3 (
        .refclk(refclk), .rst(rst), .cfg(if_3.slave),
        .outclk(outclk3), .outclk_en(outclk_en3), .locked(locked3)
    );

    always #5 refclk = ~refclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge refclk);
        #1;
    endtask

    task automatic wait_lock(input int already);
        int n = already;
        while (!locked && n < 200) begin
            tick();
            n++;
        end
        chk("lock_latency", n, 64);
    endtask

    task automatic cfg(input int ch, input int dv);
        chk("ready_before_cfg", if_m.cfg_ready, 1);
        if_m.cfg_valid = 1'b1;
        if_m.cfg_ch    = ch[0];
        if_m.cfg_div   = dv[15:0];
        tick();
        if_m.cfg_valid = 1'b0;
        chk("locked_after_cfg", locked, 0);
        chk("ready_after_cfg", if_m.cfg_ready, 0);
        chk("outclk_after_cfg", outclk, 0);
        wait_lock(0);
    endtask

    task automatic check_run(input int d0, input int d1, input int s0, input int s1, input int n);
        logic [1:0] e_clk, e_en;
        for (int k = 0; k < n; k++) begin
            e_clk[0] = ((s0 + k) % d0) < (d0 + 1) / 2;
            e_clk[1] = ((s1 + k) % d1) < (d1 + 1) / 2;
            e_en[0]  = ((s0 + k) % d0) == 0;
            e_en[1]  = ((s1 + k) % d1) == 0;
            chk("outclk", outclk, e_clk);
            chk("outclk_en", outclk_en, e_en);
            chk("locked_run", locked, 1);
            tick();
        end
    endtask

    initial begin
        int d3 [3];
        logic [2:0] e3_clk, e3_en;
        d3 = '{2, 4, 3};
        if_m.cfg_valid = 1'b0; if_m.cfg_ch = '0; if_m.cfg_div = '0;
        if_3.cfg_valid = 1'b0; if_3.cfg_ch = '0; if_3.cfg_div = '0;
`ifdef MULTI_CLK_GEN_PHASE_EN
        if_m.cfg_phase = '0;
        if_3.cfg_phase = '0;
`endif
        repeat (3) tick();
        chk("rst_outclk", outclk, 0);
        chk("rst_en", outclk_en, 0);
        chk("rst_locked", locked, 0);
        chk("rst_ready", if_m.cfg_ready, 0);
        rst = 1'b1;
        wait_lock(0);
        chk("ready_run", if_m.cfg_ready, 1);
        check_run(2, 4, 0, 0, 8);

        cfg(1, 5);
        check_run(2, 5, 0, 0, 10);

        cfg(0, 3);
        check_run(3, 5, 0, 0, 6);
        cfg(0, 0);
        check_run(2, 5, 0, 0, 6);
        cfg(0, 3);
        cfg(0, 1);
        check_run(2, 5, 0, 0, 6);

        rst = 1'b0;
        #1;
        chk("async_outclk", outclk, 0);
        chk("async_en", outclk_en, 0);
        chk("async_locked", locked, 0);
        chk("async_ready", if_m.cfg_ready, 0);
        chk("async_locked3", locked3, 0);
        repeat (3) tick();
        rst = 1'b1;
        repeat (3) tick();
        chk("settle3", locked3, 0);
        for (int k = 0; k < 12; k++) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                e3_clk[i] = (k % d3[i]) < (d3[i] + 1) / 2;
                e3_en[i]  = (k % d3[i]) == 0;
            end
            chk("oor_outclk", outclk3, e3_clk);
            chk("oor_en", outclk_en3, e3_en);
            chk("oor_locked", locked3, 1);
            chk("oor_ready", if_3.cfg_ready, 1);
            if (k == 2) begin
                if_3.cfg_valid = 1'b1;
                if_3.cfg_ch    = 2'd3;
                if_3.cfg_div   = 8'd7;
            end
            if (k == 3) if_3.cfg_valid = 1'b0;
        end
        chk("main_settling", locked, 0);
        wait_lock(15);
        check_run(2, 4, 0, 0, 8);

`ifdef MULTI_CLK_GEN_PHASE_EN
        if_m.cfg_phase = 16'd2;
        cfg(1, 4);
        check_run(2, 4, 0, 2, 6);
        if_m.cfg_phase = 16'd9;
        cfg(1, 4);
        check_run(2, 4, 0, 3, 6);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
